// File: rtl/sdram_cmd_monitor.sv
// sdram_cmd_monitor: whitebox protocol monitor for the SDRAM controller pin interface.
// Decodes raw command pins, tracks per-bank open state and open row, counts commands,
// times the refresh interval and keeps sticky protocol-error flags.
//
// Optional feature macro: SDRC_MON_TRCD_CHECK_EN builds per-bank tRCD down-counters
// and drives err_flags[3]; when undefined err_flags[3] is tied to 0.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   mon_en                monitor enable; 0 freezes state (err_clr still works)
//   cke, cs_n, ras_n, cas_n, we_n, addr, ba   SDRAM command pins
//   cfg_rfsh_max          refresh deadline in cycles (0 disables the check)
//   err_clr               clears err_flags
//   cmd_valid, cmd_code   registered decoded command
//   bank_open, open_row   per-bank open flag / latched row (bank b at [b*ADDR_W +: ADDR_W])
//   act_cnt..ref_cnt      saturating command counters
//   rfsh_timer            cycles since last REF (saturating)
//   err_flags, err_any    sticky errors {trcd, rfsh overdue, act-to-open, access-to-closed}
module sdram_cmd_monitor #(
  parameter int unsigned ADDR_W = 13,
  parameter int unsigned BA_W   = 2,
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned RFSH_W = 12,
  parameter int unsigned TRCD   = 3
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           mon_en,
  input  logic                           cke,
  input  logic                           cs_n,
  input  logic                           ras_n,
  input  logic                           cas_n,
  input  logic                           we_n,
  input  logic [ADDR_W-1:0]              addr,
  input  logic [BA_W-1:0]                ba,
  input  logic [RFSH_W-1:0]              cfg_rfsh_max,
  input  logic                           err_clr,
  output logic                           cmd_valid,
  output logic [2:0]                     cmd_code,
  output logic [(1<<BA_W)-1:0]           bank_open,
  output logic [(1<<BA_W)*ADDR_W-1:0]    open_row,
  output logic [CNT_W-1:0]               act_cnt,
  output logic [CNT_W-1:0]               rd_cnt,
  output logic [CNT_W-1:0]               wr_cnt,
  output logic [CNT_W-1:0]               pre_cnt,
  output logic [CNT_W-1:0]               ref_cnt,
  output logic [RFSH_W-1:0]              rfsh_timer,
  output logic [3:0]                     err_flags,
  output logic                           err_any
);

  localparam int unsigned NUM_BANKS = 1 << BA_W;

  typedef enum logic [2:0] {
    CmdNop = 3'd0,
    CmdAct = 3'd1,
    CmdRd  = 3'd2,
    CmdWr  = 3'd3,
    CmdPre = 3'd4,
    CmdRef = 3'd5,
    CmdLmr = 3'd6,
    CmdBst = 3'd7
  } cmd_e;

  cmd_e                  dec;
  logic                  sampled;
  logic [NUM_BANKS-1:0]  bank_open_d;
  logic [3:0]            err_new;
  logic [ADDR_W-1:0]     row_q [NUM_BANKS];

  assign sampled = mon_en & cke & ~cs_n;

  always_comb begin
    dec = CmdNop;
    if (sampled) begin
      unique case ({ras_n, cas_n, we_n})
        3'b011:  dec = CmdAct;
        3'b101:  dec = CmdRd;
        3'b100:  dec = CmdWr;
        3'b010:  dec = CmdPre;
        3'b001:  dec = CmdRef;
        3'b000:  dec = CmdLmr;
        3'b110:  dec = CmdBst;
        default: dec = CmdNop;
      endcase
    end
  end

`ifdef SDRC_MON_TRCD_CHECK_EN
  localparam int unsigned TrcdW = (TRCD > 1) ? $clog2(TRCD) : 1;
  logic [TrcdW-1:0] trcd_q [NUM_BANKS];
  logic             trcd_busy;

  assign trcd_busy = (trcd_q[ba] != '0);

  always_ff @(posedge clk) begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (reset) begin
        trcd_q[b] <= '0;
      end else if (mon_en) begin
        // A new ACT reloads even if the previous window has not expired.
        if (dec == CmdAct && ba == BA_W'(b)) begin
          trcd_q[b] <= TrcdW'(TRCD - 1);
        end else if (trcd_q[b] != '0) begin
          trcd_q[b] <= trcd_q[b] - TrcdW'(1);
        end
      end
    end
  end
`else
  logic trcd_busy;
  assign trcd_busy = 1'b0;
`endif

  // Error detection uses the pre-update bank state; all sources are gated by mon_en via dec.
  always_comb begin
    bank_open_d = bank_open;
    err_new     = '0;
    unique case (dec)
      CmdAct: begin
        err_new[1]      = bank_open[ba];
        bank_open_d[ba] = 1'b1;
      end
      CmdRd, CmdWr: begin
        err_new[0] = ~bank_open[ba];
        err_new[3] = trcd_busy;
        if (addr[10]) bank_open_d[ba] = 1'b0;
      end
      CmdPre: begin
        if (addr[10]) bank_open_d = '0;
        else          bank_open_d[ba] = 1'b0;
      end
      default: ;
    endcase
    if (mon_en && cfg_rfsh_max != '0 && rfsh_timer == cfg_rfsh_max && dec != CmdRef) begin
      err_new[2] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cmd_valid  <= 1'b0;
      cmd_code   <= 3'd0;
      bank_open  <= '0;
      act_cnt    <= '0;
      rd_cnt     <= '0;
      wr_cnt     <= '0;
      pre_cnt    <= '0;
      ref_cnt    <= '0;
      rfsh_timer <= '0;
      err_flags  <= '0;
      for (int b = 0; b < NUM_BANKS; b++) row_q[b] <= '0;
    end else begin
      cmd_valid <= (dec != CmdNop);
      cmd_code  <= dec;
      // A fresh error in the clearing cycle survives the clear.
      err_flags <= (err_clr ? 4'b0000 : err_flags) | err_new;
      if (mon_en) begin
        bank_open <= bank_open_d;
        if (dec == CmdAct) row_q[ba] <= addr;
        if (dec == CmdAct && act_cnt != '1) act_cnt <= act_cnt + CNT_W'(1);
        if (dec == CmdRd  && rd_cnt  != '1) rd_cnt  <= rd_cnt  + CNT_W'(1);
        if (dec == CmdWr  && wr_cnt  != '1) wr_cnt  <= wr_cnt  + CNT_W'(1);
        if (dec == CmdPre && pre_cnt != '1) pre_cnt <= pre_cnt + CNT_W'(1);
        if (dec == CmdRef && ref_cnt != '1) ref_cnt <= ref_cnt + CNT_W'(1);
        if (dec == CmdRef) begin
          rfsh_timer <= '0;
        end else if (rfsh_timer != '1) begin
          rfsh_timer <= rfsh_timer + RFSH_W'(1);
        end
      end
    end
  end

  always_comb begin
    open_row = '0;
    for (int b = 0; b < NUM_BANKS; b++) open_row[b*ADDR_W +: ADDR_W] = row_q[b];
  end

  assign err_any = |err_flags;

endmodule

// File: tb/tb_sdram_cmd_monitor.sv
module tb_sdram_cmd_monitor;
  localparam int ADDR_W = 13;
  localparam int BA_W   = 2;
  localparam int CNT_W  = 16;
  localparam int RFSH_W = 12;
  localparam int TRCD   = 3;
  localparam int NB     = 4;
  localparam int CMAX   = 65535;
  localparam int RMAX   = 4095;

  localparam bit [2:0] P_ACT = 3'b011, P_RD = 3'b101, P_WR = 3'b100, P_PRE = 3'b010;
  localparam bit [2:0] P_REF = 3'b001, P_NOP = 3'b111;

  logic clk = 1'b0;
  logic reset, mon_en, cke, cs_n, ras_n, cas_n, we_n, err_clr;
  logic [ADDR_W-1:0] addr;
  logic [BA_W-1:0] ba;
  logic [RFSH_W-1:0] cfg_rfsh_max;
  logic cmd_valid, err_any;
  logic [2:0] cmd_code;
  logic [NB-1:0] bank_open;
  logic [NB*ADDR_W-1:0] open_row;
  logic [CNT_W-1:0] act_cnt, rd_cnt, wr_cnt, pre_cnt, ref_cnt;
  logic [RFSH_W-1:0] rfsh_timer;
  logic [3:0] err_flags;

  always #5 clk = ~clk;

  sdram_cmd_monitor #(
    .ADDR_W(ADDR_W), .BA_W(BA_W), .CNT_W(CNT_W), .RFSH_W(RFSH_W), .TRCD(TRCD)
  ) dut (
    .clk(clk), .reset(reset), .mon_en(mon_en), .cke(cke), .cs_n(cs_n), .ras_n(ras_n),
    .cas_n(cas_n), .we_n(we_n), .addr(addr), .ba(ba), .cfg_rfsh_max(cfg_rfsh_max),
    .err_clr(err_clr), .cmd_valid(cmd_valid), .cmd_code(cmd_code), .bank_open(bank_open),
    .open_row(open_row), .act_cnt(act_cnt), .rd_cnt(rd_cnt), .wr_cnt(wr_cnt),
    .pre_cnt(pre_cnt), .ref_cnt(ref_cnt), .rfsh_timer(rfsh_timer), .err_flags(err_flags),
    .err_any(err_any)
  );

  typedef struct {
    int valid;
    int code;
    int open;
    int row[NB];
    int cnt[5];
    int rfsh;
    int err;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  // Reference model state: bank table, counters (act, rd, wr, pre, ref), refresh age, flags.
  int dec_tab[8] = '{6, 5, 4, 1, 3, 2, 7, 0};
  bit m_open[NB];
  int m_row[NB];
  int m_cnt[5];
  int m_rfsh;
  bit [3:0] m_err;
  int m_code;
  int en_idx;
  int act_idx[NB];
  int cur_rfmax = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sat(input int v, input int mx);
    return (v >= mx) ? mx : v + 1;
  endfunction

  task automatic model_cycle(input bit rst, input bit en, input bit ck, input bit csn,
                             input bit [2:0] rcw, input int a, input int b, input bit clr);
    exp_t e;
    int code;
    bit [3:0] ne;
    if (rst) begin
      for (int i = 0; i < NB; i++) begin
        m_open[i] = 0; m_row[i] = 0; act_idx[i] = -100;
      end
      for (int i = 0; i < 5; i++) m_cnt[i] = 0;
      m_rfsh = 0; m_err = 0; m_code = 0; en_idx = 0;
    end else begin
      code = (en && ck && !csn) ? dec_tab[rcw] : 0;
      ne = 4'b0000;
      if (code == 1 && m_open[b]) ne[1] = 1'b1;
      if (code == 2 || code == 3) begin
        if (!m_open[b]) ne[0] = 1'b1;
`ifdef SDRC_MON_TRCD_CHECK_EN
        if (en_idx - act_idx[b] < TRCD) ne[3] = 1'b1;
`endif
      end
      if (en && cur_rfmax != 0 && m_rfsh == cur_rfmax && code != 5) ne[2] = 1'b1;
      m_err = (clr ? 4'b0000 : m_err) | ne;
      if (en) begin
        case (code)
          1: begin
            m_open[b] = 1; m_row[b] = a; act_idx[b] = en_idx; m_cnt[0] = sat(m_cnt[0], CMAX);
          end
          2, 3: begin
            if (((a >> 10) & 1) == 1) m_open[b] = 0;
            m_cnt[code - 1] = sat(m_cnt[code - 1], CMAX);
          end
          4: begin
            if (((a >> 10) & 1) == 1) begin
              for (int i = 0; i < NB; i++) m_open[i] = 0;
            end else begin
              m_open[b] = 0;
            end
            m_cnt[3] = sat(m_cnt[3], CMAX);
          end
          5: m_cnt[4] = sat(m_cnt[4], CMAX);
          default: ;
        endcase
        m_rfsh = (code == 5) ? 0 : sat(m_rfsh, RMAX);
        en_idx++;
      end
      m_code = code;
    end
    e.valid = (m_code != 0) ? 1 : 0;
    e.code = m_code;
    e.open = 0;
    for (int i = 0; i < NB; i++) begin
      if (m_open[i]) e.open = e.open | (1 << i);
      e.row[i] = m_row[i];
    end
    e.cnt = m_cnt;
    e.rfsh = m_rfsh;
    e.err = int'(m_err);
    q.push_back(e);
  endtask

  task automatic step(input bit rst, input bit en, input bit ck, input bit csn,
                      input bit [2:0] rcw, input int a, input int b, input bit clr);
    @(negedge clk);
    reset = rst; mon_en = en; cke = ck; cs_n = csn;
    {ras_n, cas_n, we_n} = rcw;
    addr = ADDR_W'(a); ba = BA_W'(b); err_clr = clr;
    cfg_rfsh_max = RFSH_W'(cur_rfmax);
    model_cycle(rst, en, ck, csn, rcw, a & 32'h1fff, b & 3, clr);
  endtask

  task automatic cmd(input bit [2:0] rcw, input int a, input int b);
    step(1'b0, 1'b1, 1'b1, 1'b0, rcw, a, b, 1'b0);
  endtask

  task automatic nop(input int n);
    for (int i = 0; i < n; i++) cmd(P_NOP, 0, 0);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b1, 1'b1, 1'b1, P_NOP, 0, 0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b1, P_NOP, 0, 0, 1'b0);
  endtask

  // Scoreboard monitor: compares every registered update against the queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        check("cmd_valid", int'(cmd_valid), e.valid);
        check("cmd_code", int'(cmd_code), e.code);
        check("bank_open", int'(bank_open), e.open);
        for (int i = 0; i < NB; i++) check("open_row", int'(open_row[i*ADDR_W +: ADDR_W]), e.row[i]);
        check("act_cnt", int'(act_cnt), e.cnt[0]);
        check("rd_cnt", int'(rd_cnt), e.cnt[1]);
        check("wr_cnt", int'(wr_cnt), e.cnt[2]);
        check("pre_cnt", int'(pre_cnt), e.cnt[3]);
        check("ref_cnt", int'(ref_cnt), e.cnt[4]);
        check("rfsh_timer", int'(rfsh_timer), e.rfsh);
        check("err_flags", int'(err_flags), e.err);
        check("err_any", int'(err_any), (e.err != 0) ? 1 : 0);
      end
    end
  end

  initial begin
    bit [2:0] rcw;
    int exp_trcd;
    reset = 1'b1; mon_en = 1'b0; cke = 1'b0; cs_n = 1'b1;
    {ras_n, cas_n, we_n} = P_NOP; addr = '0; ba = '0; err_clr = 1'b0; cfg_rfsh_max = '0;

    // 1: ACT then RD after tRCD.
    do_reset();
    nop(1);
    check("reset_act_cnt", int'(act_cnt), 0);
    check("reset_bank_open", int'(bank_open), 0);
    check("reset_err_flags", int'(err_flags), 0);
    cmd(P_ACT, 'h0123, 1);
    nop(3);
    cmd(P_RD, 'h0010, 1);
    nop(1);
    check("t1_act_cnt", int'(act_cnt), 1);
    check("t1_rd_cnt", int'(rd_cnt), 1);
    check("t1_bank_open", int'(bank_open), 'b0010);
    check("t1_open_row1", int'(open_row[ADDR_W +: ADDR_W]), 'h0123);
    check("t1_err_flags", int'(err_flags), 0);

    // 2: RD to closed bank, then clear.
    cmd(P_RD, 0, 2);
    nop(1);
    check("t2_err_flags", int'(err_flags), 'b0001);
    check("t2_err_any", int'(err_any), 1);
    step(1'b0, 1'b1, 1'b1, 1'b0, P_NOP, 0, 0, 1'b1);
    nop(1);
    check("t2_cleared", int'(err_flags), 0);

    // 3: double ACT then precharge-all.
    cmd(P_ACT, 'h0055, 0);
    cmd(P_ACT, 'h0066, 0);
    cmd(P_PRE, 'h0400, 0);
    nop(1);
    check("t3_err_flags", int'(err_flags), 'b0010);
    check("t3_pre_cnt", int'(pre_cnt), 1);
    check("t3_bank_open", int'(bank_open), 0);

    // 4: refresh overdue, then REF.
    do_reset();
    cur_rfmax = 10;
    nop(12);
    check("t4_overdue", int'(err_flags[2]), 1);
    cmd(P_REF, 0, 0);
    nop(1);
    check("t4_rfsh_timer", int'(rfsh_timer), 0);
    check("t4_ref_cnt", int'(ref_cnt), 1);
    cur_rfmax = 0;

    // 5: WR one cycle after ACT.
    do_reset();
    cmd(P_ACT, 'h0abc, 3);
    cmd(P_WR, 'h0004, 3);
    nop(1);
`ifdef SDRC_MON_TRCD_CHECK_EN
    exp_trcd = 1;
`else
    exp_trcd = 0;
`endif
    check("t5_trcd_flag", int'(err_flags[3]), exp_trcd);
    check("t5_wr_cnt", int'(wr_cnt), 1);

    // Randomised traffic against the reference model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) cur_rfmax = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(3, 40);
      rcw = 3'($urandom_range(0, 7));
      if (rcw == P_REF && $urandom_range(0, 3) != 0) rcw = P_NOP;
      step(($urandom_range(0, 399) == 0), ($urandom_range(0, 9) != 0),
           ($urandom_range(0, 9) != 0), ($urandom_range(0, 4) == 0), rcw,
           int'($urandom_range(0, 8191)), int'($urandom_range(0, 3)),
           ($urandom_range(0, 19) == 0));
    end
    cur_rfmax = 0;

    // 6b: mon_en=0 with ACT on the pins.
    do_reset();
    cmd(P_ACT, 'h0011, 0);
    step(1'b0, 1'b0, 1'b1, 1'b0, P_ACT, 'h0022, 1, 1'b0);
    nop(1);
    check("t6_act_cnt_frozen", int'(act_cnt), 1);
    check("t6_cmd_valid", int'(cmd_valid), 0);
    check("t6_bank_open", int'(bank_open), 'b0001);

    // 6a: read counter saturation.
    nop(3);
    for (int i = 0; i < 66000; i++) cmd(P_RD, 0, 0);
    nop(1);
    check("t6_rd_cnt_sat", int'(rd_cnt), 'hffff);

    @(posedge clk);
    #2;
    check("queue_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
